// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART controller blocks.
//   tx_state_t      : transmit serializer FSM states
//   parity_t        : frame parity mode
//   UART_IDLE_LEVEL : level of the serial line when nothing is sent
//   parity_bit()    : parity bit for a given mode from the XOR of the data bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Even parity makes the total number of ones even, so the bit equals the
    // XOR of the data; odd parity is its inverse. PAR_NONE never transmits it.
    function automatic logic parity_bit(input parity_t mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Serializes one byte per frame onto txd: start bit, DATA_BITS data bits
// LSB-first, optional parity bit, STOP_BITS stop bits. Each bit lasts from one
// baud_tick to the next; tx_en starts the baud tick generator on accept and
// tx_done stops it on the final stop-bit tick.
//
// Ports
//   clk_16mhz : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_data   : byte to send, sampled on accept
//   in_valid  : in_data is valid
//   in_ready  : block can accept (IDLE only, registered)
//   baud_tick : one-cycle bit-period strobe from the generator
//   tx_en     : one-cycle start request to the generator (combinational)
//   tx_done   : stop request to the generator (combinational, high in reset)
//   txd       : serial line, idle high (registered)
//   busy      : a frame is in progress (registered)
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic                 clk_16mhz,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 baud_tick,
    output logic                 tx_en,
    output logic                 tx_done,
    output logic                 txd,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic accept;
    logic last_stop;

    assign accept    = in_valid & in_ready_q;
    assign last_stop = (state_q == TX_STOP) && (stop_cnt_q == LAST_STOP);

    // Generator handshake: tx_en can only occur in IDLE and tx_done only in
    // STOP or reset, and tx_en is masked by reset, so they never overlap.
    // tx_done is held during reset because the generator's enable has no reset.
    assign tx_en   = accept & ~rst;
    assign tx_done = (last_stop & baud_tick) | rst;

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign txd      = txd_q;

    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no path through
        // the case statements leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;

        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    shift_d    = in_data;
                    parity_d   = parity_bit(PARITY, ^in_data);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    // Counter stops at the last bit instead of wrapping.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (last_stop) state_d    = TX_IDLE;
                    else           stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the state being entered, so txd changes on the
        // same edge as the state and is glitch-free from a flop.
        unique case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_d[0];
            TX_PARITY: txd_d = parity_d;
            default:   txd_d = UART_IDLE_LEVEL;
        endcase

        in_ready_d = (state_d == TX_IDLE);
        busy_d     = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk_16mhz) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before this edge.
        if (rst) begin
            // NOTE: the shift register and parity flop are cleared as well, so
            // a frame aborted by reset leaves no partial data behind.
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            txd_q      <= UART_IDLE_LEVEL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Directed bench for uart_tx_serializer. Five instances cover 8N1, 8E1, 8N2,
// 8O1 and 5N1. Instances 0..3 are driven by a small model of the baud tick
// generator (16 cycles per bit, started by tx_en, stopped by tx_done);
// instance 4 is driven by a hand-stepped tick with random spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int NDUT  = 5;
    localparam int BIT_N = 16;

    logic            clk_16mhz;
    logic            rst;
    logic [7:0]      in_data;
    logic [NDUT-1:0] in_valid;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] baud_tick;
    logic [NDUT-1:0] tx_en;
    logic [NDUT-1:0] tx_done;
    logic [NDUT-1:0] txd;
    logic [NDUT-1:0] busy;
    logic [3:0]      gen_tick;
    logic            stub_tick;

    int checks   = 0;
    int failures = 0;

    logic exp_bits [12];
    int   exp_len;

    initial clk_16mhz = 1'b0;
    always #5 clk_16mhz = ~clk_16mhz;

    // Baud tick generator model: counts while enabled, ticks every BIT_N cycles.
    for (genvar g = 0; g < 4; g++) begin : g_gen
        logic       en;
        logic [3:0] cnt;
        always @(posedge clk_16mhz) begin
            if (tx_done[g]) begin
                en  <= 1'b0;
                cnt <= 4'd0;
            end else if (tx_en[g]) begin
                en  <= 1'b1;
                cnt <= 4'd0;
            end else if (en) begin
                cnt <= cnt + 4'd1;
            end
        end
        assign gen_tick[g] = en && (cnt == 4'(BIT_N - 1));
    end

    assign baud_tick = {stub_tick, gen_tick};

    uart_tx_serializer u_8n1 (
        .clk_16mhz(clk_16mhz), .rst(rst), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .baud_tick(baud_tick[0]), .tx_en(tx_en[0]),
        .tx_done(tx_done[0]), .txd(txd[0]), .busy(busy[0])
    );

    uart_tx_serializer #(.PARITY(uart_pkg::PAR_EVEN)) u_8e1 (
        .clk_16mhz(clk_16mhz), .rst(rst), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .baud_tick(baud_tick[1]), .tx_en(tx_en[1]),
        .tx_done(tx_done[1]), .txd(txd[1]), .busy(busy[1])
    );

    uart_tx_serializer #(.STOP_BITS(2)) u_8n2 (
        .clk_16mhz(clk_16mhz), .rst(rst), .in_data(in_data), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .baud_tick(baud_tick[2]), .tx_en(tx_en[2]),
        .tx_done(tx_done[2]), .txd(txd[2]), .busy(busy[2])
    );

    uart_tx_serializer #(.PARITY(uart_pkg::PAR_ODD)) u_8o1 (
        .clk_16mhz(clk_16mhz), .rst(rst), .in_data(in_data), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .baud_tick(baud_tick[3]), .tx_en(tx_en[3]),
        .tx_done(tx_done[3]), .txd(txd[3]), .busy(busy[3])
    );

    uart_tx_serializer #(.DATA_BITS(5)) u_5n1 (
        .clk_16mhz(clk_16mhz), .rst(rst), .in_data(in_data[4:0]), .in_valid(in_valid[4]),
        .in_ready(in_ready[4]), .baud_tick(baud_tick[4]), .tx_en(tx_en[4]),
        .tx_done(tx_done[4]), .txd(txd[4]), .busy(busy[4])
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected line levels of one frame, one entry per bit period.
    task automatic build_frame(input logic [7:0] data, input int dbits, input int par, input int nstop);
        logic dx;
        dx         = 1'b0;
        exp_bits[0] = 1'b0;
        exp_len    = 1;
        for (int i = 0; i < dbits; i++) begin
            exp_bits[exp_len] = data[i];
            dx = dx ^ data[i];
            exp_len++;
        end
        if (par == 1) begin
            exp_bits[exp_len] = dx;
            exp_len++;
        end else if (par == 2) begin
            exp_bits[exp_len] = ~dx;
            exp_len++;
        end
        for (int i = 0; i < nstop; i++) begin
            exp_bits[exp_len] = 1'b1;
            exp_len++;
        end
    endtask

    // Called mid-cycle; presents data and returns at the first negedge of the frame.
    task automatic accept(input int idx, input logic [7:0] data);
        int waited;
        waited = 0;
        while (in_ready[idx] !== 1'b1 && waited < 40) begin
            @(negedge clk_16mhz);
            #1;
            waited++;
        end
        check($sformatf("ready_timeout_dut%0d", idx), 32'(waited < 40), 32'd1);
        in_data       = data;
        in_valid[idx] = 1'b1;
        #1;
        check($sformatf("tx_en_on_accept_dut%0d", idx), 32'(tx_en[idx]), 32'd1);
        @(negedge clk_16mhz);
    endtask

    // Checks every cycle of a generator-timed frame starting at its first
    // negedge. mode 0: in_valid low; 1: in_valid held with next_data;
    // 2: in_valid and in_data randomised. ncheck >= 0 stops after that many cycles.
    task automatic frame_check(input int idx, input logic [7:0] data, input int dbits, input int par,
                               input int nstop, input int mode, input logic [7:0] next_data,
                               input int ncheck);
        build_frame(data, dbits, par, nstop);
        for (int c = 0; c < exp_len * BIT_N; c++) begin
            if (ncheck >= 0 && c == ncheck) return;
            case (mode)
                1: begin in_valid[idx] = 1'b1; in_data = next_data; end
                2: begin in_valid[idx] = 1'($urandom_range(0, 1)); in_data = 8'($urandom); end
                default: in_valid[idx] = 1'b0;
            endcase
            #1;
            check($sformatf("txd_dut%0d_c%0d", idx, c), 32'(txd[idx]), 32'(exp_bits[c / BIT_N]));
            check($sformatf("tx_done_dut%0d_c%0d", idx, c), 32'(tx_done[idx]),
                  32'(c == exp_len * BIT_N - 1));
            check($sformatf("tx_en_busy_dut%0d_c%0d", idx, c), 32'(tx_en[idx]), 32'd0);
            check($sformatf("in_ready_busy_dut%0d_c%0d", idx, c), 32'(in_ready[idx]), 32'd0);
            check($sformatf("busy_dut%0d_c%0d", idx, c), 32'(busy[idx]), 32'd1);
            @(negedge clk_16mhz);
        end
        if (mode == 2) in_valid[idx] = 1'b0;
        #1;
        check($sformatf("idle_txd_dut%0d", idx), 32'(txd[idx]), 32'd1);
        check($sformatf("idle_busy_dut%0d", idx), 32'(busy[idx]), 32'd0);
        check($sformatf("idle_ready_dut%0d", idx), 32'(in_ready[idx]), 32'd1);
        check($sformatf("idle_done_dut%0d", idx), 32'(tx_done[idx]), 32'd0);
        check($sformatf("idle_tx_en_dut%0d", idx), 32'(tx_en[idx]), 32'(mode == 1));
    endtask

    // 5N1 frame on instance 4 with randomly spaced stub ticks.
    task automatic stub_frame(input logic [7:0] data);
        int gap;
        build_frame(data, 5, 0, 1);
        accept(4, data);
        in_valid[4] = 1'b0;
        for (int k = 0; k < exp_len; k++) begin
            gap = $urandom_range(1, 20);
            for (int g = 0; g < gap; g++) begin
                stub_tick = (g == gap - 1);
                #1;
                check($sformatf("stub_txd_b%0d_g%0d", k, g), 32'(txd[4]), 32'(exp_bits[k]));
                check($sformatf("stub_busy_b%0d", k), 32'(busy[4]), 32'd1);
                check($sformatf("stub_done_b%0d_g%0d", k, g), 32'(tx_done[4]),
                      32'(stub_tick && k == exp_len - 1));
                @(negedge clk_16mhz);
            end
        end
        stub_tick = 1'b0;
        #1;
        check("stub_end_txd", 32'(txd[4]), 32'd1);
        check("stub_end_busy", 32'(busy[4]), 32'd0);
        check("stub_end_ready", 32'(in_ready[4]), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = 8'h00;
        stub_tick = 1'b0;

        // Reset state, with in_valid high to show tx_en stays gated.
        @(negedge clk_16mhz);
        @(negedge clk_16mhz);
        in_valid = '1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_txd_dut%0d", i), 32'(txd[i]), 32'd1);
            check($sformatf("rst_ready_dut%0d", i), 32'(in_ready[i]), 32'd0);
            check($sformatf("rst_busy_dut%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_done_dut%0d", i), 32'(tx_done[i]), 32'd1);
            check($sformatf("rst_tx_en_dut%0d", i), 32'(tx_en[i]), 32'd0);
        end
        @(negedge clk_16mhz);
        in_valid = '0;
        rst      = 1'b0;
        #1;
        check("release_done", 32'(tx_done[0]), 32'd0);
        check("release_ready_low", 32'(in_ready[0]), 32'd0);
        @(negedge clk_16mhz);
        #1;
        check("release_ready_high", 32'(in_ready), 32'h1F);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit.
        accept(0, 8'h55);
        frame_check(0, 8'h55, 8, 0, 1, 0, 8'h00, -1);

        // Parity: even 0x07 and odd 0x0F both give a parity bit of 1.
        accept(1, 8'h07);
        frame_check(1, 8'h07, 8, 1, 1, 0, 8'h00, -1);
        accept(3, 8'h0F);
        frame_check(3, 8'h0F, 8, 2, 1, 0, 8'h00, -1);

        // Two stop bits, in_valid held: 0xA5 then 0x3C after one IDLE cycle.
        accept(2, 8'hA5);
        frame_check(2, 8'hA5, 8, 0, 2, 1, 8'h3C, -1);
        @(negedge clk_16mhz);
        frame_check(2, 8'h3C, 8, 0, 2, 0, 8'h00, -1);

        // in_valid and in_data churn while busy: byte from the accept edge is sent.
        accept(0, 8'h96);
        frame_check(0, 8'h96, 8, 0, 1, 2, 8'h00, -1);

        // Reset during data bit 3 of 0xC3 (bit 3 is 0 on the line).
        accept(0, 8'hC3);
        frame_check(0, 8'hC3, 8, 0, 1, 0, 8'h00, 70);
        rst = 1'b1;
        #1;
        check("abort_done_comb", 32'(tx_done[0]), 32'd1);
        check("abort_txd_before_edge", 32'(txd[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_16mhz);
            #1;
            check($sformatf("abort_txd_%0d", i), 32'(txd[0]), 32'd1);
            check($sformatf("abort_busy_%0d", i), 32'(busy[0]), 32'd0);
            check($sformatf("abort_ready_%0d", i), 32'(in_ready[0]), 32'd0);
            check($sformatf("abort_done_%0d", i), 32'(tx_done[0]), 32'd1);
            check($sformatf("abort_gen_tick_%0d", i), 32'(gen_tick[0]), 32'd0);
        end
        @(negedge clk_16mhz);
        rst = 1'b0;
        #1;
        accept(0, 8'hC3);
        frame_check(0, 8'hC3, 8, 0, 1, 0, 8'h00, -1);

        // Stub ticks: a tick in IDLE changes nothing.
        stub_tick = 1'b1;
        #1;
        check("idle_tick_tx_done", 32'(tx_done[4]), 32'd0);
        @(negedge clk_16mhz);
        stub_tick = 1'b0;
        #1;
        check("idle_tick_busy", 32'(busy[4]), 32'd0);
        check("idle_tick_txd", 32'(txd[4]), 32'd1);
        check("idle_tick_ready", 32'(in_ready[4]), 32'd1);

        // 5-bit frames: only the 5 LSBs go out.
        stub_frame(8'hFF);
        stub_frame(8'h3A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
